// File: rtl/clkdiv_ctrl_pkg.sv
// Shared types and helpers for the clock-division controller.
package clkdiv_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    localparam int unsigned MIN_DIV = 2;

    // Ratios below MIN_DIV cannot produce both a high and a low phase.
    function automatic int unsigned clamp_div(input int unsigned div);
        return (div < MIN_DIV) ? MIN_DIV : div;
    endfunction

endpackage

// File: rtl/div_period_cnt.sv
// Loadable wrap counter: counts 0..limit-1 while en, held at 0 by clr.
// Latency: wrap is combinational from cnt/limit; no backpressure.
// Backpressure: none, advances every enabled cycle.
module div_period_cnt #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] cnt,
    output logic             wrap
);

    assign wrap = en && (cnt == (limit - WIDTH'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + WIDTH'(1);
        end
    end

endmodule

// File: rtl/clkdiv_ctrl.sv
// Divided-clock generator with glitch-free start/stop and period-aligned ratio updates.
// Latency: outputs registered one cycle behind the counter; ratio applies at next period boundary.
// Backpressure: cfg_ready drops while a ratio is pending, until the current period wraps.
module clkdiv_ctrl
    import clkdiv_ctrl_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             cfg_valid,
    input  logic [WIDTH-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             clkout,
    output logic             tick,
    output logic             busy,
    output logic             err
);

    localparam logic [WIDTH-1:0] DIV_INIT = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] MIN_W    = WIDTH'(MIN_DIV);

    state_t           state;
    logic [WIDTH-1:0] div_reg;
    logic [WIDTH-1:0] pend_reg;
    logic [WIDTH-1:0] cnt;
    logic             wrap;
    logic             xfer;
    logic [WIDTH-1:0] div_clamped;
    logic             running;

    assign running     = (state != IDLE);
    assign cfg_ready   = (state != PEND);
    assign xfer        = cfg_valid && cfg_ready;
    assign div_clamped = WIDTH'(clamp_div(32'(cfg_div)));

    div_period_cnt #(.WIDTH(WIDTH)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!running),
        .en    (running),
        .limit (div_reg),
        .cnt   (cnt),
        .wrap  (wrap)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            div_reg  <= DIV_INIT;
            pend_reg <= '0;
            clkout   <= 1'b0;
            tick     <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
        end else begin
            // Waveform decodes the count of the cycle just finished, so the
            // last cycle of every period is low and stopping at a wrap is clean.
            clkout <= running && (cnt < (div_reg >> 1));
            tick   <= running && (cnt == '0);
            err    <= xfer && (cfg_div < MIN_W);

            case (state)
                IDLE: begin
                    if (xfer) div_reg <= div_clamped;
                    if (enable) begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (wrap && !enable) begin
                        // A ratio offered on the stopping wrap is applied directly.
                        if (xfer) div_reg <= div_clamped;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (xfer) begin
                        pend_reg <= div_clamped;
                        state    <= PEND;
                    end
                end
                PEND: begin
                    if (wrap) begin
                        div_reg <= pend_reg;
                        if (enable) begin
                            state <= RUN;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Directed bench for clkdiv_ctrl: cycle-by-cycle waveform patterns with hand-derived expectations.
module tb_clkdiv_ctrl;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       cfg_valid;
    logic [7:0] cfg_div;
    logic       cfg_ready;
    logic       clkout;
    logic       tick;
    logic       busy;
    logic       err;

    int n_checks;
    int n_fail;

    clkdiv_ctrl #(.WIDTH(8), .DEFAULT_DIV(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .clkout    (clkout),
        .tick      (tick),
        .busy      (busy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One character per cycle; sampled just after each rising edge.
    task automatic wave(input string tag, input string cpat, input string tpat);
        for (int i = 0; i < cpat.len(); i++) begin
            step();
            check($sformatf("%s_clk[%0d]", tag, i), 32'(clkout), 32'(cpat[i] == "1"));
            check($sformatf("%s_tick[%0d]", tag, i), 32'(tick), 32'(tpat[i] == "1"));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        enable    = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = 8'd0;
        step();
        step();
        check("rst_clkout", 32'(clkout), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_ready", 32'(cfg_ready), 32'd1);

        // Default ratio 3: high 1, low 2
        rst_n  = 1'b1;
        enable = 1'b1;
        wave("def", "0100100100", "0100100100");
        check("def_busy", 32'(busy), 32'd1);

        // Runtime change to 8 in mid-period
        wave("chg_pre", "1", "1");
        cfg_valid = 1'b1;
        cfg_div   = 8'd8;
        check("chg_ready_before", 32'(cfg_ready), 32'd1);
        step();
        cfg_valid = 1'b0;
        check("chg_ready_pend", 32'(cfg_ready), 32'd0);
        check("chg_clk_a", 32'(clkout), 32'd0);
        step();
        check("chg_clk_b", 32'(clkout), 32'd0);
        check("chg_ready_after", 32'(cfg_ready), 32'd1);
        wave("chg", "1111000011110000", "1000000010000000");

        // Stop at a period boundary, ratio 8
        enable = 1'b0;
        wave("stop8", "1111000", "1000000");
        check("stop8_busy_run", 32'(busy), 32'd1);
        wave("stop8_end", "0", "0");
        check("stop8_busy_idle", 32'(busy), 32'd0);
        wave("idle8", "00", "00");

        // Clamp of ratio 0 in IDLE
        cfg_valid = 1'b1;
        cfg_div   = 8'd0;
        step();
        cfg_valid = 1'b0;
        check("clamp_err", 32'(err), 32'd1);
        step();
        check("clamp_err_clear", 32'(err), 32'd0);
        enable = 1'b1;
        wave("clamp", "01010", "01010");

        // Load ratio 5 while running, then graceful stop
        cfg_valid = 1'b1;
        cfg_div   = 8'd5;
        step();
        cfg_valid = 1'b0;
        check("n5_ready_pend", 32'(cfg_ready), 32'd0);
        check("n5_clk_a", 32'(clkout), 32'd1);
        check("n5_err", 32'(err), 32'd0);
        step();
        check("n5_clk_b", 32'(clkout), 32'd0);
        wave("n5", "1", "1");
        enable = 1'b0;
        wave("stop5_a", "100", "000");
        check("stop5_busy_run", 32'(busy), 32'd1);
        wave("stop5_b", "0", "0");
        check("stop5_busy_idle", 32'(busy), 32'd0);
        wave("idle5", "00", "00");

        // Collision: ratio 4 offered on a wrap with ratio 6
        cfg_valid = 1'b1;
        cfg_div   = 8'd6;
        enable    = 1'b1;
        step();
        cfg_valid = 1'b0;
        check("col_start_clk", 32'(clkout), 32'd0);
        check("col_start_busy", 32'(busy), 32'd1);
        wave("col6", "11100", "10000");
        cfg_valid = 1'b1;
        cfg_div   = 8'd4;
        check("col_ready_wrap", 32'(cfg_ready), 32'd1);
        step();
        cfg_valid = 1'b0;
        check("col_clk_wrap", 32'(clkout), 32'd0);
        check("col_ready_pend", 32'(cfg_ready), 32'd0);
        wave("col6b", "111000", "100000");
        wave("col4", "11001100", "10001000");
        check("col_ready_after", 32'(cfg_ready), 32'd1);

        // Async reset while a ratio is pending
        cfg_valid = 1'b1;
        cfg_div   = 8'd9;
        step();
        cfg_valid = 1'b0;
        check("ar_pend_ready", 32'(cfg_ready), 32'd0);
        check("ar_clk_before", 32'(clkout), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_clkout", 32'(clkout), 32'd0);
        check("ar_tick", 32'(tick), 32'd0);
        check("ar_busy", 32'(busy), 32'd0);
        check("ar_ready", 32'(cfg_ready), 32'd1);
        step();
        step();
        rst_n = 1'b1;
        wave("ar_post", "0100100", "0100100");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
